// File: rtl/axis_len_to_keep.sv
// Frame command (length, start lane) to per-beat keep/last descriptors; first beat 1 cycle after accept.
// Outputs are registered and held while beat_ready is low; the next command is taken on the final-beat handshake.
module axis_len_to_keep #(
  parameter int C_DATA_BYTES = 8,
  parameter int C_LEN_WIDTH  = 16,
  parameter int C_OFS_WIDTH  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [C_LEN_WIDTH-1:0]  cmd_len,
  input  logic [C_OFS_WIDTH-1:0]  cmd_ofs,
  output logic                    beat_valid,
  input  logic                    beat_ready,
  output logic [C_DATA_BYTES-1:0] beat_keep,
  output logic                    beat_last,
  output logic [C_LEN_WIDTH-1:0]  beat_cnt,
  output logic                    zero_len
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [C_LEN_WIDTH-1:0] LP_BEAT_BYTES = C_LEN_WIDTH'(C_DATA_BYTES);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [C_DATA_BYTES-1:0] r_keep;
  logic                    r_last;
  logic [C_LEN_WIDTH-1:0]  r_cnt;
  logic [C_LEN_WIDTH-1:0]  r_rem;
  logic                    r_zero_len;

  logic                    w_cmd_acc;
  logic                    w_beat_hs;
  logic                    w_len_zero;
  logic                    w_load_first;
  logic [C_LEN_WIDTH-1:0]  w_ofs_ext;
  logic [C_LEN_WIDTH-1:0]  w_avail;
  logic [C_LEN_WIDTH-1:0]  w_n_first;
  logic [C_LEN_WIDTH-1:0]  w_n_next;
  logic [C_DATA_BYTES-1:0] w_keep_first;
  logic [C_DATA_BYTES-1:0] w_keep_next;

  assign w_cmd_acc    = cmd_valid && cmd_ready;
  assign w_beat_hs    = beat_valid && beat_ready;
  assign w_len_zero   = (cmd_len == '0);
  assign w_load_first = w_cmd_acc && !w_len_zero;

  // n never exceeds the bytes still owed, so remaining cannot underflow.
  assign w_ofs_ext = C_LEN_WIDTH'(cmd_ofs);
  assign w_avail   = LP_BEAT_BYTES - w_ofs_ext;
  assign w_n_first = (cmd_len < w_avail) ? cmd_len : w_avail;
  assign w_n_next  = (r_rem < LP_BEAT_BYTES) ? r_rem : LP_BEAT_BYTES;

  always_comb begin
    w_keep_first = '0;
    w_keep_next  = '0;
    for (int i = 0; i < C_DATA_BYTES; i++) begin
      w_keep_first[i] = (C_LEN_WIDTH'(i) >= w_ofs_ext) &&
                        (C_LEN_WIDTH'(i) < (w_ofs_ext + w_n_first));
      w_keep_next[i]  = (C_LEN_WIDTH'(i) < w_n_next);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_load_first) w_state_nxt = S_RUN;
      S_RUN:   if (w_beat_hs && r_last) w_state_nxt = w_load_first ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    beat_valid = (r_state == S_RUN);
    cmd_ready  = (r_state == S_IDLE) || ((r_state == S_RUN) && beat_ready && r_last);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_keep     <= '0;
      r_last     <= 1'b0;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_zero_len <= 1'b0;
    end else begin
      r_zero_len <= w_cmd_acc && w_len_zero;
      if (w_load_first) begin
        r_keep <= w_keep_first;
        r_last <= (cmd_len == w_n_first);
        r_rem  <= cmd_len - w_n_first;
        r_cnt  <= '0;
      end else if (w_beat_hs && !r_last) begin
        r_keep <= w_keep_next;
        r_last <= (r_rem == w_n_next);
        r_rem  <= r_rem - w_n_next;
        r_cnt  <= r_cnt + 1'b1;
      end else if (w_beat_hs) begin
        // Frame finished with no follow-on command: park the descriptor at zero.
        r_keep <= '0;
        r_last <= 1'b0;
        r_cnt  <= '0;
        r_rem  <= '0;
      end
    end
  end

  assign beat_keep = r_keep;
  assign beat_last = r_last;
  assign beat_cnt  = r_cnt;
  assign zero_len  = r_zero_len;

endmodule

// File: tb/tb_axis_len_to_keep.sv
// Directed bench for axis_len_to_keep with 8-byte beats: table of single frames plus
// hand-written sequences for backpressure, zero length, back-to-back, reset and max length.
module tb_axis_len_to_keep;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic [2:0]  cmd_ofs;
  logic        beat_valid;
  logic        beat_ready;
  logic [7:0]  beat_keep;
  logic        beat_last;
  logic [15:0] beat_cnt;
  logic        zero_len;

  int n_cmp = 0;
  int n_err = 0;

  axis_len_to_keep #(
    .C_DATA_BYTES(8),
    .C_LEN_WIDTH (16),
    .C_OFS_WIDTH (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_ofs   (cmd_ofs),
    .beat_valid(beat_valid),
    .beat_ready(beat_ready),
    .beat_keep (beat_keep),
    .beat_last (beat_last),
    .beat_cnt  (beat_cnt),
    .zero_len  (zero_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     len;
    logic [2:0]      ofs;
    int              nb;
    logic [5:0][7:0] keeps;  // element 0 is the first beat
  } vec_t;

  vec_t tbl [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [7:0] e37 [6];
    logic [7:0] prev_keep;
    int         idx;
    int         pop;
    int         cyc;
    int         nbeats;
    int         bad_keep;
    logic [7:0] last_keep;
    logic [15:0] last_cnt;

    tbl[0] = '{len:16'd20, ofs:3'd0, nb:3, keeps:{8'h00, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'hFF}};
    tbl[1] = '{len:16'd4,  ofs:3'd3, nb:1, keeps:{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h78}};
    tbl[2] = '{len:16'd10, ofs:3'd6, nb:2, keeps:{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hC0}};
    tbl[3] = '{len:16'd8,  ofs:3'd0, nb:1, keeps:{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF}};
    tbl[4] = '{len:16'd1,  ofs:3'd7, nb:1, keeps:{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80}};
    e37 = '{8'hE0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_ofs = '0; beat_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(beat_valid), 32'd0);
    chk("rst_keep",  32'(beat_keep),  32'd0);
    chk("rst_last",  32'(beat_last),  32'd0);
    chk("rst_cnt",   32'(beat_cnt),   32'd0);
    chk("rst_zlen",  32'(zero_len),   32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      cmd_valid = 1'b1; cmd_len = tbl[v].len; cmd_ofs = tbl[v].ofs; beat_ready = 1'b1;
      #1;
      chk("tbl_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      for (int b = 0; b < tbl[v].nb; b++) begin
        chk("tbl_valid", 32'(beat_valid), 32'd1);
        chk("tbl_keep",  32'(beat_keep),  32'(tbl[v].keeps[b]));
        chk("tbl_last",  32'(beat_last),  32'(b == tbl[v].nb - 1));
        chk("tbl_cnt",   32'(beat_cnt),   32'(b));
        tick();
      end
      chk("tbl_idle_valid", 32'(beat_valid), 32'd0);
      chk("tbl_idle_ready", 32'(cmd_ready),  32'd1);
    end

    cmd_valid = 1'b1; cmd_len = 16'd0; cmd_ofs = 3'd2;
    tick();
    cmd_valid = 1'b0;
    chk("zl_pulse", 32'(zero_len),   32'd1);
    chk("zl_valid", 32'(beat_valid), 32'd0);
    chk("zl_ready", 32'(cmd_ready),  32'd1);
    tick();
    chk("zl_pulse_end", 32'(zero_len),   32'd0);
    chk("zl_valid2",    32'(beat_valid), 32'd0);

    // Random backpressure on a 37-byte frame starting at lane 5.
    cmd_valid = 1'b1; cmd_len = 16'd37; cmd_ofs = 3'd5; beat_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    idx = 0; pop = 0; cyc = 0; prev_keep = 8'h00;
    while (idx < 6 && cyc < 200) begin
      chk("bp_valid", 32'(beat_valid), 32'd1);
      chk("bp_keep",  32'(beat_keep),  32'(e37[idx]));
      chk("bp_last",  32'(beat_last),  32'(idx == 5));
      chk("bp_cnt",   32'(beat_cnt),   32'(idx));
      if (cyc > 0 && !beat_ready) chk("bp_hold_keep", 32'(beat_keep), 32'(prev_keep));
      beat_ready = 1'($urandom_range(0, 1));
      #1;
      chk("bp_cmd_ready", 32'(cmd_ready), 32'(beat_ready && idx == 5));
      prev_keep = beat_keep;
      if (beat_ready) begin
        pop += $countones(beat_keep);
        idx++;
      end
      tick();
      cyc++;
    end
    chk("bp_done",   32'(idx), 32'd6);
    chk("bp_popcnt", 32'(pop), 32'd37);
    chk("bp_idle",   32'(beat_valid), 32'd0);

    // Back-to-back: second command rides the final-beat handshake.
    beat_ready = 1'b1;
    cmd_valid = 1'b1; cmd_len = 16'd20; cmd_ofs = 3'd0;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("b2b_last1", 32'(beat_last), 32'd1);
    chk("b2b_cnt1",  32'(beat_cnt),  32'd2);
    cmd_valid = 1'b1; cmd_len = 16'd3; cmd_ofs = 3'd0;
    #1;
    chk("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_valid", 32'(beat_valid), 32'd1);
    chk("b2b_keep",  32'(beat_keep),  32'h07);
    chk("b2b_last",  32'(beat_last),  32'd1);
    chk("b2b_cnt",   32'(beat_cnt),   32'd0);

    // Zero-length command on the final-beat handshake.
    cmd_valid = 1'b1; cmd_len = 16'd0;
    tick();
    cmd_valid = 1'b0;
    chk("b2bz_pulse", 32'(zero_len),   32'd1);
    chk("b2bz_valid", 32'(beat_valid), 32'd0);

    // Reset mid-frame discards the frame.
    cmd_valid = 1'b1; cmd_len = 16'd37; cmd_ofs = 3'd0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("mid_cnt_pre", 32'(beat_cnt), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_valid", 32'(beat_valid), 32'd0);
    chk("mrst_keep",  32'(beat_keep),  32'd0);
    chk("mrst_last",  32'(beat_last),  32'd0);
    chk("mrst_cnt",   32'(beat_cnt),   32'd0);
    chk("mrst_zlen",  32'(zero_len),   32'd0);
    tick();
    chk("mrst_no_beats", 32'(beat_valid), 32'd0);
    chk("mrst_ready",    32'(cmd_ready),  32'd1);

    // Maximum legal length: 65535 = 8191 full beats + 7 bytes.
    cmd_valid = 1'b1; cmd_len = 16'hFFFF; cmd_ofs = 3'd0;
    tick();
    cmd_valid = 1'b0;
    nbeats = 0; bad_keep = 0; last_keep = 8'h00; last_cnt = '0;
    while (beat_valid && nbeats < 9000) begin
      if (!beat_last && beat_keep != 8'hFF) bad_keep++;
      if (beat_last) begin
        last_keep = beat_keep;
        last_cnt  = beat_cnt;
      end
      nbeats++;
      tick();
    end
    chk("max_beats",     32'(nbeats),    32'd8192);
    chk("max_full_keep", 32'(bad_keep),  32'd0);
    chk("max_last_keep", 32'(last_keep), 32'h7F);
    chk("max_last_cnt",  32'(last_cnt),  32'd8191);
    chk("max_idle",      32'(beat_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_len_to_keep.md
Name: axis_len_to_keep

Overview:
- Parametrised, sequential successor to the single-beat count-to-keep decoder.
- Accepts a frame command (byte length plus starting byte-lane offset) and emits one keep mask and one last flag per data beat over a valid/ready stream.
- Sits in the 10GbE DMA/TX path beside the AXI-Stream data mover. The data path consumes one beat descriptor per data beat, so tkeep and tlast are generated for arbitrary length and alignment.

Parameters:
- C_DATA_BYTES, 8: bytes per beat (power of 2, 4..64); keep width.
- C_LEN_WIDTH, 16: width of the frame byte-length field.
- C_OFS_WIDTH, 3: width of the start-offset field; must equal log2(C_DATA_BYTES).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_len  in  C_LEN_WIDTH  frame length in bytes.
- cmd_ofs  in  C_OFS_WIDTH  byte lane of the first valid byte in the first beat.
- beat_valid  out  1  beat descriptor valid.
- beat_ready  in  1  downstream accepts the beat.
- beat_keep  out  C_DATA_BYTES  byte-enable mask for the beat; bit i is lane i.
- beat_last  out  1  final beat of the frame.
- beat_cnt  out  C_LEN_WIDTH  index of the current beat within the frame, 0-based.
- zero_len  out  1  one-cycle pulse when a zero-length command is accepted.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values (rst_n low at a clock edge): state IDLE, beat_valid=0, beat_keep=0, beat_last=0, beat_cnt=0, zero_len=0, internal remaining count=0.
- A reset mid-frame discards the frame. No further beats are emitted for it.
- States: IDLE, RUN.
- IDLE:
  - cmd_ready=1.
  - On accept with cmd_len=0: stay in IDLE, pulse zero_len for one cycle, emit no beats.
  - On accept with cmd_len>0: go to RUN and register the first beat so that beat_valid=1 on the next cycle (latency 1 from accept to first beat_valid).
- First beat:
  - n = min(cmd_len, C_DATA_BYTES - cmd_ofs).
  - beat_keep = ((1<<n)-1) << cmd_ofs.
  - remaining = cmd_len - n.
  - beat_last = (remaining == 0).
- Subsequent beats, loaded on each handshake while remaining > 0:
  - n = min(remaining, C_DATA_BYTES).
  - beat_keep = (1<<n)-1 (lanes contiguous from lane 0).
  - remaining -= n.
  - beat_last = (remaining == 0).
  - beat_cnt increments by 1.
- Stream rule: beat_keep, beat_last and beat_cnt are held stable while beat_valid=1 and beat_ready=0. Registered outputs only; there is no combinational path from beat_ready to beat_keep or beat_last.
- Handshake of a beat with beat_last=1:
  - If cmd_valid is high in the same cycle, it is accepted in that cycle. cmd_ready = (IDLE) or (beat_valid and beat_ready and beat_last). The next frame's first beat follows with zero bubbles, and beat_cnt restarts at 0.
  - Otherwise go to IDLE with beat_valid=0.
  - If the same-cycle command has cmd_len=0, zero_len pulses and the block goes to IDLE.
- cmd_ready=0 in RUN except on the final-beat handshake cycle.
- Arithmetic: remaining is C_LEN_WIDTH bits and never underflows (n <= remaining). cmd_len equal to the maximum value (2^C_LEN_WIDTH - 1) is legal.
- beat_keep is never all-zero while beat_valid=1.

Test Plan:
- C_DATA_BYTES=8, cmd_len=20, cmd_ofs=0, beat_ready=1 -> beats keep=0xFF, 0xFF, 0x0F; last only on the third beat; beat_cnt 0,1,2; first beat_valid one cycle after accept.
- cmd_len=4, cmd_ofs=3 -> single beat keep=0x78, last=1, then IDLE with cmd_ready=1.
- cmd_len=10, cmd_ofs=6 -> keep=0xC0, then keep=0xFF with last=1; cmd_len=8, cmd_ofs=0 -> one beat keep=0xFF, last=1.
- cmd_len=0 accepted -> zero_len high for exactly one cycle, beat_valid stays 0, cmd_ready stays 1.
- Random beat_ready backpressure on cmd_len=37, cmd_ofs=5 -> outputs stable while stalled; keeps 0xE0, 0xFF, 0xFF, 0xFF, 0xFF, 0x03; total popcount = 37.
- Back-to-back: second command (cmd_len=3, cmd_ofs=0) held valid during the final beat of the first frame -> accepted on the final-beat handshake; next cycle shows keep=0x07, last=1, beat_cnt=0 with no idle cycle. Then rst_n=0 for one cycle mid-frame -> beat_valid=0 the next cycle and all outputs at their reset values.
